// File: rtl/ibex_data_bus_arbiter.sv
// ibex_data_bus_arbiter
//   Shares the core data-memory port between the load/store unit (M0) and a secondary
//   bus master (M1, debug SBA / DMA). One master is selected per grant. A request stalled
//   by the memory stays on the same master until granted. An in-order owner FIFO records
//   which master issued each outstanding transaction, so every response is routed back to
//   its issuer.
//
//   Ports
//     clk_i, rst_ni               clock, asynchronous active-low reset
//     mX_req/we/be/addr/wdata_i   master request + payload (req held until granted)
//     m0_lock_i                   LSU busy: M0 keeps the bus until it drops
//     mX_gnt/rvalid/err_o         per-master grant and response
//     mx_rdata_o                  read data broadcast to both masters
//     data_*_o / data_*_i         downstream memory port
//     outstanding_o               granted-but-unanswered count
//     spurious_rvalid_o           response arrived with nothing outstanding (dropped)
//
//   Build option
//     DBUS_ARB_RR_EN  defined: round-robin between non-held, non-locked requesters.
//                     undefined: fixed priority M0 > M1.
module ibex_data_bus_arbiter #(
    parameter int unsigned MaxOutstanding = 2,
    parameter int unsigned IdxW           = $clog2(MaxOutstanding + 1) - 1
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            m0_req_i,
    input  logic            m0_we_i,
    input  logic [3:0]      m0_be_i,
    input  logic [31:0]     m0_addr_i,
    input  logic [31:0]     m0_wdata_i,
    input  logic            m0_lock_i,
    output logic            m0_gnt_o,
    output logic            m0_rvalid_o,
    output logic            m0_err_o,
    input  logic            m1_req_i,
    input  logic            m1_we_i,
    input  logic [3:0]      m1_be_i,
    input  logic [31:0]     m1_addr_i,
    input  logic [31:0]     m1_wdata_i,
    output logic            m1_gnt_o,
    output logic            m1_rvalid_o,
    output logic            m1_err_o,
    output logic [31:0]     mx_rdata_o,
    output logic            data_req_o,
    output logic            data_we_o,
    output logic [3:0]      data_be_o,
    output logic [31:0]     data_addr_o,
    output logic [31:0]     data_wdata_o,
    input  logic            data_gnt_i,
    input  logic            data_rvalid_i,
    input  logic            data_err_i,
    input  logic [31:0]     data_rdata_i,
    output logic [IdxW:0]   outstanding_o,
    output logic            spurious_rvalid_o
);

    localparam int unsigned PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
    localparam logic [IdxW:0]   CountMax = (IdxW + 1)'(MaxOutstanding);
    localparam logic [PtrW-1:0] PtrLast  = PtrW'(MaxOutstanding - 1);

    logic                      sel;          // 0 = M0, 1 = M1
    logic                      hold_q;
    logic                      hold_id_q;
    logic                      lock_q;
    logic [IdxW:0]             count_q;
    logic [IdxW:0]             count_d;
    logic [PtrW-1:0]           wr_ptr_q;
    logic [PtrW-1:0]           rd_ptr_q;
    logic [MaxOutstanding-1:0] owner_q;
    logic                      full;
    logic                      push;
    logic                      pop;
    logic                      head_id;

`ifdef DBUS_ARB_RR_EN
    logic rr_ptr_q;                          // master preferred for the next fresh grant
`endif

    // A stalled request stays on its master; the lock pins the bus to M0 even in idle
    // cycles between the halves of a split access.
    always_comb begin
        sel = 1'b0;
        if (hold_q) begin
            sel = hold_id_q;
        end else if (lock_q) begin
            sel = 1'b0;
        end else begin
`ifdef DBUS_ARB_RR_EN
            if (rr_ptr_q) begin
                sel = m1_req_i | ~m0_req_i;
            end else begin
                sel = ~m0_req_i & m1_req_i;
            end
`else
            sel = ~m0_req_i & m1_req_i;
`endif
        end
    end

    assign full         = (count_q == CountMax);
    assign data_req_o   = (sel ? m1_req_i : m0_req_i) & ~full;
    assign data_we_o    = sel ? m1_we_i    : m0_we_i;
    assign data_be_o    = sel ? m1_be_i    : m0_be_i;
    assign data_addr_o  = sel ? m1_addr_i  : m0_addr_i;
    assign data_wdata_o = sel ? m1_wdata_i : m0_wdata_i;

    assign m0_gnt_o = data_gnt_i & data_req_o & ~sel;
    assign m1_gnt_o = data_gnt_i & data_req_o & sel;

    assign push    = data_req_o & data_gnt_i;
    assign pop     = data_rvalid_i & (count_q != '0);
    assign head_id = owner_q[rd_ptr_q];

    // Responses go to the oldest outstanding issuer; with nothing outstanding they are dropped.
    assign m0_rvalid_o       = pop & ~head_id;
    assign m1_rvalid_o       = pop & head_id;
    assign m0_err_o          = pop & ~head_id & data_err_i;
    assign m1_err_o          = pop & head_id & data_err_i;
    assign mx_rdata_o        = data_rdata_i;
    assign spurious_rvalid_o = data_rvalid_i & (count_q == '0);
    assign outstanding_o     = count_q;

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hold_q    <= 1'b0;
            hold_id_q <= 1'b0;
            lock_q    <= 1'b0;
            count_q   <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            owner_q   <= '0;
        end else begin
            lock_q  <= m0_lock_i;
            count_q <= count_d;
            if (data_req_o) begin
                hold_q    <= ~data_gnt_i;
                hold_id_q <= sel;
            end
            if (push) begin
                owner_q[wr_ptr_q] <= sel;
                wr_ptr_q          <= (wr_ptr_q == PtrLast) ? '0 : wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= (rd_ptr_q == PtrLast) ? '0 : rd_ptr_q + 1'b1;
            end
        end
    end

`ifdef DBUS_ARB_RR_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr_q <= 1'b0;
        end else if (push) begin
            rr_ptr_q <= ~sel;
        end
    end
`endif

endmodule

// File: tb/tb_ibex_data_bus_arbiter.sv
// Randomised bench for ibex_data_bus_arbiter: two protocol-abiding masters, a random memory
// (grant / response / error), random LSU lock and a mid-run reset, checked every cycle
// against a queue-based model of ownership, stall, lock and capacity rules.
module tb_ibex_data_bus_arbiter;

    localparam int MAX = 2;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        m0_req_i = 0, m0_we_i = 0, m0_lock_i = 0;
    logic [3:0]  m0_be_i = 0;
    logic [31:0] m0_addr_i = 0, m0_wdata_i = 0;
    logic        m1_req_i = 0, m1_we_i = 0;
    logic [3:0]  m1_be_i = 0;
    logic [31:0] m1_addr_i = 0, m1_wdata_i = 0;
    logic        m0_gnt_o, m0_rvalid_o, m0_err_o, m1_gnt_o, m1_rvalid_o, m1_err_o;
    logic [31:0] mx_rdata_o;
    logic        data_req_o, data_we_o;
    logic [3:0]  data_be_o;
    logic [31:0] data_addr_o, data_wdata_o;
    logic        data_gnt_i = 0, data_rvalid_i = 0, data_err_i = 0;
    logic [31:0] data_rdata_i = 0;
    logic [1:0]  outstanding_o;
    logic        spurious_rvalid_o;

    always #5 clk_i = ~clk_i;

    ibex_data_bus_arbiter #(.MaxOutstanding(MAX)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .m0_req_i(m0_req_i), .m0_we_i(m0_we_i), .m0_be_i(m0_be_i), .m0_addr_i(m0_addr_i),
        .m0_wdata_i(m0_wdata_i), .m0_lock_i(m0_lock_i),
        .m0_gnt_o(m0_gnt_o), .m0_rvalid_o(m0_rvalid_o), .m0_err_o(m0_err_o),
        .m1_req_i(m1_req_i), .m1_we_i(m1_we_i), .m1_be_i(m1_be_i), .m1_addr_i(m1_addr_i),
        .m1_wdata_i(m1_wdata_i),
        .m1_gnt_o(m1_gnt_o), .m1_rvalid_o(m1_rvalid_o), .m1_err_o(m1_err_o),
        .mx_rdata_o(mx_rdata_o),
        .data_req_o(data_req_o), .data_we_o(data_we_o), .data_be_o(data_be_o),
        .data_addr_o(data_addr_o), .data_wdata_o(data_wdata_o),
        .data_gnt_i(data_gnt_i), .data_rvalid_i(data_rvalid_i), .data_err_i(data_err_i),
        .data_rdata_i(data_rdata_i),
        .outstanding_o(outstanding_o), .spurious_rvalid_o(spurious_rvalid_o)
    );

    int checks = 0;
    int failures = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got=%h expected=%h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Master stimulus state (payload stays stable while a request is pending).
    logic        mreq   [2];
    logic        mwe    [2];
    logic [3:0]  mbe    [2];
    logic [31:0] maddr  [2];
    logic [31:0] mwdata [2];
    logic        lock_v;

    // Reference model state.
    int q[$];          // issuer ids of outstanding transactions, oldest first
    bit hold_v;        // a request was presented and not granted last cycle
    int hold_id;
    bit lock_prev;     // lock level seen at the previous edge
    bit rr;            // preferred master for a fresh grant (round-robin build)

    task automatic new_request(input int m);
        mreq[m]   = 1'b1;
        mwe[m]    = 1'($urandom_range(0, 1));
        mbe[m]    = 4'($urandom_range(1, 15));
        maddr[m]  = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
        mwdata[m] = $urandom;
    endtask

    task automatic reset_model();
        q.delete();
        hold_v    = 0;
        hold_id   = 0;
        lock_prev = 0;
        rr        = 0;
    endtask

    task automatic do_cycle();
        int  sel;
        bit  full, exp_req, exp_gnt, rsp;
        int  head;
        @(negedge clk_i);
        m0_req_i = mreq[0]; m0_we_i = mwe[0]; m0_be_i = mbe[0];
        m0_addr_i = maddr[0]; m0_wdata_i = mwdata[0]; m0_lock_i = lock_v;
        m1_req_i = mreq[1]; m1_we_i = mwe[1]; m1_be_i = mbe[1];
        m1_addr_i = maddr[1]; m1_wdata_i = mwdata[1];
        data_gnt_i    = ($urandom_range(0, 99) < 60);
        data_rvalid_i = (q.size() > 0) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 9) == 0);
        data_err_i    = ($urandom_range(0, 3) == 0);
        data_rdata_i  = $urandom;
        #1;
        full = (q.size() >= MAX);
        if (hold_v) sel = hold_id;
        else if (lock_prev) sel = 0;
`ifdef DBUS_ARB_RR_EN
        else if (rr) sel = mreq[1] ? 1 : (mreq[0] ? 0 : 1);
`endif
        else sel = mreq[0] ? 0 : (mreq[1] ? 1 : 0);
        exp_req = mreq[sel] && !full;
        exp_gnt = exp_req && data_gnt_i;
        check_val("data_req", 32'(data_req_o), 32'(exp_req));
        if (exp_req) begin
            check_val("data_addr",  data_addr_o,  maddr[sel]);
            check_val("data_we",    32'(data_we_o), 32'(mwe[sel]));
            check_val("data_be",    32'(data_be_o), 32'(mbe[sel]));
            check_val("data_wdata", data_wdata_o, mwdata[sel]);
        end
        check_val("m0_gnt", 32'(m0_gnt_o), 32'(exp_gnt && sel == 0));
        check_val("m1_gnt", 32'(m1_gnt_o), 32'(exp_gnt && sel == 1));
        rsp  = data_rvalid_i && q.size() > 0;
        head = (q.size() > 0) ? q[0] : 0;
        check_val("m0_rvalid", 32'(m0_rvalid_o), 32'(rsp && head == 0));
        check_val("m1_rvalid", 32'(m1_rvalid_o), 32'(rsp && head == 1));
        check_val("m0_err", 32'(m0_err_o), 32'(rsp && head == 0 && data_err_i));
        check_val("m1_err", 32'(m1_err_o), 32'(rsp && head == 1 && data_err_i));
        check_val("spurious", 32'(spurious_rvalid_o), 32'(data_rvalid_i && q.size() == 0));
        check_val("outstanding", 32'(outstanding_o), 32'(q.size()));
        if (rsp) check_val("rdata", mx_rdata_o, data_rdata_i);
        @(posedge clk_i);
        if (rsp) begin
            $display("[%0t] response M%0d rdata=%h err=%b", $time, head, data_rdata_i, data_err_i);
            void'(q.pop_front());
        end else if (data_rvalid_i) begin
            $display("[%0t] spurious response dropped", $time);
        end
        if (exp_gnt) begin
            $display("[%0t] grant M%0d addr=%h we=%b", $time, sel, maddr[sel], mwe[sel]);
            q.push_back(sel);
            hold_v  = 0;
            rr      = (sel == 0);
            mreq[sel] = 1'b0;
        end else if (exp_req) begin
            hold_v  = 1;
            hold_id = sel;
        end
        lock_prev = lock_v;
        for (int m = 0; m < 2; m++)
            if (!mreq[m] && $urandom_range(0, 1) == 1) new_request(m);
        if ($urandom_range(0, 9) == 0) lock_v = ~lock_v;
    endtask

    task automatic apply_reset();
        @(negedge clk_i);
        rst_ni = 1'b0;
        m0_req_i = 0; m1_req_i = 0; m0_lock_i = 0; lock_v = 0;
        data_gnt_i = 0; data_rvalid_i = 1; data_err_i = 0;
        #1;
        check_val("rst_outstanding", 32'(outstanding_o), 32'd0);
        check_val("rst_m0_rvalid", 32'(m0_rvalid_o), 32'd0);
        check_val("rst_m1_rvalid", 32'(m1_rvalid_o), 32'd0);
        check_val("rst_data_req", 32'(data_req_o), 32'd0);
        data_rvalid_i = 0;
        #1;
        rst_ni = 1'b1;
        reset_model();
    endtask

    initial begin
        for (int m = 0; m < 2; m++) begin
            mreq[m] = 0; mwe[m] = 0; mbe[m] = 0; maddr[m] = 0; mwdata[m] = 0;
        end
        lock_v = 0;
        reset_model();
        repeat (2) @(posedge clk_i);
        #1;
        check_val("reset_data_req", 32'(data_req_o), 32'd0);
        check_val("reset_m0_gnt", 32'(m0_gnt_o), 32'd0);
        check_val("reset_m1_gnt", 32'(m1_gnt_o), 32'd0);
        check_val("reset_outstanding", 32'(outstanding_o), 32'd0);
        check_val("reset_spurious", 32'(spurious_rvalid_o), 32'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        for (int c = 0; c < 1500; c++) begin
            if (c == 750) apply_reset();
            do_cycle();
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
